// File: rtl/alu_arbiter_seq.sv
// rtl/alu_arbiter_seq.sv - round-robin arbiter and sequencer for the shared 8-bit ALU
module alu_arbiter_seq #(
    parameter int DATA_W     = 8,
    parameter int OP_W       = 4,
    parameter int RESULT_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic              i_req0_cin,
    input  logic [OP_W-1:0]   i_req0_op,
    input  logic              i_req0_flag_en,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    input  logic              i_req1_cin,
    input  logic [OP_W-1:0]   i_req1_op,
    input  logic              i_req1_flag_en,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [4:0]        o_flags,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic              o_alu_cin,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_alu_sel,
    output logic              o_flag_sel,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic              i_zr,
    input  logic              i_ng,
    input  logic              i_pa,
    input  logic              i_co,
    input  logic              i_of,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RESULT_LAT);

    state_t     state;
    logic       last_grant;
    logic       flag_en_q;
    logic [2:0] wait_cnt;
    logic       grant_any;
    logic       grant_id;

    // Round-robin pick: on a tie the requester not granted last wins
    always_comb begin
        grant_any = i_req0_valid | i_req1_valid;
        grant_id  = (i_req0_valid && i_req1_valid) ? ~last_grant : i_req1_valid;
    end

    // Ready is only offered in IDLE; gated by reset so outputs read 0 during reset
    assign o_req0_ready = !i_rst && (state == IDLE) && i_req0_valid && !grant_id;
    assign o_req1_ready = !i_rst && (state == IDLE) && i_req1_valid && grant_id;

    // Sequencer: grant, strobe the ALU, wait out its latency, hold the response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            flag_en_q   <= 1'b0;
            wait_cnt    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= 1'b0;
            o_rsp_data  <= '0;
            o_flags     <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_cin   <= 1'b0;
            o_alu_op    <= '0;
            o_alu_sel   <= 1'b0;
            o_flag_sel  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_id;
                        o_rsp_id   <= grant_id;
                        o_alu_a    <= grant_id ? i_req1_a : i_req0_a;
                        o_alu_b    <= grant_id ? i_req1_b : i_req0_b;
                        o_alu_cin  <= grant_id ? i_req1_cin : i_req0_cin;
                        o_alu_op   <= grant_id ? i_req1_op : i_req0_op;
                        flag_en_q  <= grant_id ? i_req1_flag_en : i_req0_flag_en;
                        o_flag_sel <= grant_id ? i_req1_flag_en : i_req0_flag_en;
                        o_alu_sel  <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_alu_sel  <= 1'b0;
                    o_flag_sel <= 1'b0;
                    wait_cnt   <= LAT_LOAD;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        o_rsp_data  <= i_alu_out;
                        if (flag_en_q) begin
                            o_flags <= {i_of, i_co, i_pa, i_ng, i_zr};
                        end
                        o_rsp_valid <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
